// File: rtl/dac_spi_tx_if.sv
// dac_spi_tx_if
//   Bundles the filter-side word stream and the DAC-side SPI pins of
//   dac_spi_tx.
//   slave  : the DAC transmitter's view.
//   master : the view of the filter that drives it, which also watches the pins.
//   Filter side : dv_in, chan_in, data_in (into the transmitter)
//   DAC side    : sclk_out, cs_n_out, sdo_out (out of the transmitter)
//   Status      : busy_out, dv_out, chan_out (out of the transmitter)
interface dac_spi_tx_if #(
  parameter int W_CHAN = 5,
  parameter int W_DIN  = 16
);
  logic              dv_in;
  logic [W_CHAN-1:0] chan_in;
  logic [W_DIN-1:0]  data_in;
  logic              sclk_out;
  logic              cs_n_out;
  logic              sdo_out;
  logic              busy_out;
  logic              dv_out;
  logic [W_CHAN-1:0] chan_out;

  modport slave (
    input  dv_in, chan_in, data_in,
    output sclk_out, cs_n_out, sdo_out, busy_out, dv_out, chan_out
  );

  modport master (
    output dv_in, chan_in, data_in,
    input  sclk_out, cs_n_out, sdo_out, busy_out, dv_out, chan_out
  );
endinterface

// File: rtl/dac_spi_tx.sv
// dac_spi_tx
//   Latches the newest code per channel from the channel-tagged filter
//   stream. Pending channels are sent round-robin as SPI write frames of the
//   form {CMD, chan[3:0], code}, MSB first, to a multichannel DAC.
//   Ports:
//     clk_in : system clock
//     rst_in : asynchronous, active-low reset
//     bus    : dac_spi_tx_if.slave
//              dv_in/chan_in/data_in  : input word stream
//              sclk_out/cs_n_out/sdo_out : SPI pins
//              busy_out : status
//              dv_out/chan_out : frame-done strobe and the channel it sent
module dac_spi_tx #(
  parameter int         W_CHAN    = 5,
  parameter int         N_CHAN    = 8,
  parameter int         W_DIN     = 16,
  parameter logic [3:0] CMD       = 4'h3,
  parameter int         SCLK_HALF = 2,
  parameter int         CS_HOLD   = 4
) (
  input logic        clk_in,
  input logic        rst_in,
  dac_spi_tx_if.slave bus
);
  localparam int W_FRAME = 8 + W_DIN;
  localparam int DW = $clog2(2*SCLK_HALF + 1);
  localparam int BW = $clog2(W_FRAME + 1);
  localparam int HW = $clog2(CS_HOLD + 1);

  typedef enum logic [2:0] {IDLE, SEL, LOAD, SHIFT, HOLD} state_t;

  state_t                          state_q;
  logic [N_CHAN-1:0]               pend_q, pend_d;
  logic [N_CHAN-1:0][W_DIN-1:0]    val_q;
  logic [3:0]                      rr_q, sel_q, arb_sel;
  logic                            arb_hit;
  logic [W_FRAME-1:0]              sh_q, frame;
  logic [W_DIN-1:0]                cur_val;
  logic [DW-1:0]                   div_q;
  logic [BW-1:0]                   bit_q;
  logic [HW-1:0]                   hold_q;
  logic                            sclk_q, cs_n_q, sdo_q, busy_q, dvo_q;
  logic [W_CHAN-1:0]               cho_q;
  logic                            wr_en, hold_done;

  assign wr_en     = bus.dv_in && (int'(bus.chan_in) < N_CHAN);
  assign hold_done = (hold_q == HW'(CS_HOLD - 1));

  // First pending channel at or after rr_q; if none, the lowest pending one
  // (which is necessarily below rr_q), i.e. a wrapping search.
  always_comb begin
    arb_hit = 1'b0;
    arb_sel = '0;
    for (int j = 0; j < N_CHAN; j++)
      if (!arb_hit && pend_q[j] && j >= int'(rr_q)) begin
        arb_hit = 1'b1;
        arb_sel = 4'(j);
      end
    for (int j = 0; j < N_CHAN; j++)
      if (!arb_hit && pend_q[j]) begin
        arb_hit = 1'b1;
        arb_sel = 4'(j);
      end
  end

  always_comb begin
    cur_val = '0;
    for (int j = 0; j < N_CHAN; j++)
      if (sel_q == 4'(j)) cur_val = val_q[j];
  end

  assign frame = {CMD, sel_q, cur_val};

  // Clear-on-select comes first and the new write comes second, so a write
  // landing in the SEL cycle re-arms the channel.
  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < N_CHAN; j++)
      if (state_q == SEL && arb_sel == 4'(j)) pend_d[j] = 1'b0;
    for (int j = 0; j < N_CHAN; j++)
      if (wr_en && int'(bus.chan_in) == j) pend_d[j] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      pend_q  <= '0;
      val_q   <= '0;
      rr_q    <= '0;
      sel_q   <= '0;
      sh_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      dvo_q   <= 1'b0;
      cho_q   <= '0;
    end else begin
      pend_q <= pend_d;
      for (int j = 0; j < N_CHAN; j++)
        if (wr_en && int'(bus.chan_in) == j) val_q[j] <= bus.data_in;
      dvo_q <= 1'b0;
      // busy_q tracks the state the block enters on this edge.
      busy_q <= (|pend_d) |
                ((state_q != IDLE) & ~((state_q == HOLD) & hold_done & ~(|pend_q)));
      case (state_q)
        IDLE: if (|pend_q) state_q <= SEL;
        SEL: begin
          sel_q   <= arb_sel;
          rr_q    <= (int'(arb_sel) == N_CHAN - 1) ? 4'd0 : arb_sel + 4'd1;
          state_q <= LOAD;
        end
        LOAD: begin
          sh_q    <= frame;
          cs_n_q  <= 1'b0;
          sdo_q   <= frame[W_FRAME-1];
          sclk_q  <= 1'b0;
          div_q   <= '0;
          bit_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (div_q == DW'(SCLK_HALF - 1)) begin
            sclk_q <= 1'b1;
            div_q  <= div_q + DW'(1);
          end else if (div_q == DW'(2*SCLK_HALF - 1)) begin
            // End of bit: sclk falls, and sdo moves on at the same edge.
            sclk_q <= 1'b0;
            div_q  <= '0;
            if (bit_q == BW'(W_FRAME - 1)) begin
              cs_n_q  <= 1'b1;
              sdo_q   <= 1'b0;
              dvo_q   <= 1'b1;
              cho_q   <= W_CHAN'(sel_q);
              hold_q  <= '0;
              state_q <= HOLD;
            end else begin
              sh_q  <= sh_q << 1;
              sdo_q <= sh_q[W_FRAME-2];
              bit_q <= bit_q + BW'(1);
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        HOLD: begin
          if (hold_done) state_q <= (|pend_q) ? SEL : IDLE;
          else           hold_q  <= hold_q + HW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sclk_out = sclk_q;
  assign bus.cs_n_out = cs_n_q;
  assign bus.sdo_out  = sdo_q;
  assign bus.busy_out = busy_q;
  assign bus.dv_out   = dvo_q;
  assign bus.chan_out = cho_q;
endmodule
